// File: rtl/hi_lo_register_file_if.sv
// ---------------------------------------------------------------------------
// hi_lo_register_file_if
// Bundles the HI/LO register-pair datapath signals between the EX/MEM stage
// (master) and the HI/LO register file (slave).
//   WriteHiData / WriteLoData : operands for write, madd or msub
//   WriteEn / Madd / Msub     : update controls (priority WriteEn > Madd > Msub)
//   ReadHi / ReadLo           : current HI/LO contents, no read latency
// ---------------------------------------------------------------------------
interface hi_lo_register_file_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] WriteHiData;
    logic [WIDTH-1:0] WriteLoData;
    logic             WriteEn;
    logic             Madd;
    logic             Msub;
    logic [WIDTH-1:0] ReadHi;
    logic [WIDTH-1:0] ReadLo;

    modport master (
        output WriteHiData,
        output WriteLoData,
        output WriteEn,
        output Madd,
        output Msub,
        input  ReadHi,
        input  ReadLo
    );

    modport slave (
        input  WriteHiData,
        input  WriteLoData,
        input  WriteEn,
        input  Madd,
        input  Msub,
        output ReadHi,
        output ReadLo
    );
endinterface

// File: rtl/hi_lo_register_file.sv
// ---------------------------------------------------------------------------
// hi_lo_register_file
// HI/LO special-register pair for the MIPS datapath. Supports a plain load,
// multiply-accumulate (madd) and multiply-subtract (msub), all in place.
// Ports:
//   Clk      : system clock, updates on the rising edge
//   Reset_n  : asynchronous active-low reset, clears HI and LO
//   bus      : slave side of hi_lo_register_file_if (operands, controls,
//              ReadHi/ReadLo driven straight from the state registers)
// HI and LO are independent WIDTH-bit lanes: no carry or borrow ever crosses
// from LO into HI.
// ---------------------------------------------------------------------------
module hi_lo_register_file #(
    parameter int WIDTH = 32
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    hi_lo_register_file_if.slave        bus
);

    typedef enum logic [1:0] {
        OpHold = 2'd0,
        OpLoad = 2'd1,
        OpAdd  = 2'd2,
        OpSub  = 2'd3
    } opSel_e;

    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] hiNext_s;
    logic [WIDTH-1:0] loNext_s;
    opSel_e           op_s;

    // One lane's next value; the sum/difference is truncated to WIDTH bits,
    // which is what keeps each lane's carry/borrow from leaking anywhere.
    function automatic logic [WIDTH-1:0] laneNext(
        input opSel_e           op,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] operand
    );
        logic [WIDTH-1:0] result;
        case (op)
            OpLoad:  result = operand;
            OpAdd:   result = cur + operand;
            OpSub:   result = cur - operand;
            OpHold:  result = cur;
            default: result = cur;
        endcase
        return result;
    endfunction

    // Priority decode of the update controls; lower-priority requests are dropped.
    always_comb begin
        op_s = OpHold;
        if (bus.WriteEn) begin
            op_s = OpLoad;
        end else if (bus.Madd) begin
            op_s = OpAdd;
        end else if (bus.Msub) begin
            op_s = OpSub;
        end else begin
            op_s = OpHold;
        end
    end

    // Next-state computation for both lanes.
    always_comb begin
        hiNext_s = laneNext(op_s, hi_r, bus.WriteHiData);
        loNext_s = laneNext(op_s, lo_r, bus.WriteLoData);
    end

    // HI/LO state registers with asynchronous clear.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
        end else begin
            hi_r <= hiNext_s;
            lo_r <= loNext_s;
        end
    end

    assign bus.ReadHi = hi_r;
    assign bus.ReadLo = lo_r;

endmodule

// File: tb/tb_hi_lo_register_file.sv
// ---------------------------------------------------------------------------
// tb_hi_lo_register_file
// Directed self-checking bench for hi_lo_register_file. Expected values are
// hand-computed constants.
// ---------------------------------------------------------------------------
module tb_hi_lo_register_file;

    localparam int WIDTH = 32;

    logic Clk;
    logic Reset_n;
    int   vecCount;
    int   errCount;

    hi_lo_register_file_if #(.WIDTH(WIDTH)) bus ();

    hi_lo_register_file #(.WIDTH(WIDTH)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Drive one set of controls/operands for exactly one rising edge, then
    // idle the controls; outputs are then sampled 1 time unit after the edge.
    task automatic drive_cycle(input logic we, input logic ma, input logic ms,
                               input logic [WIDTH-1:0] h, input logic [WIDTH-1:0] l);
        bus.WriteEn     = we;
        bus.Madd        = ma;
        bus.Msub        = ms;
        bus.WriteHiData = h;
        bus.WriteLoData = l;
        @(posedge Clk);
        #1;
        bus.WriteEn = 1'b0;
        bus.Madd    = 1'b0;
        bus.Msub    = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        bus.WriteEn = 1'b0; bus.Madd = 1'b0; bus.Msub = 1'b0;
        bus.WriteHiData = 32'h0; bus.WriteLoData = 32'h0;
        #2;
        vecCount++; if (bus.ReadHi !== 32'h0) begin errCount++; $display("FAIL reset_hi: got %h want %h", bus.ReadHi, 32'h0); end
        vecCount++; if (bus.ReadLo !== 32'h0) begin errCount++; $display("FAIL reset_lo: got %h want %h", bus.ReadLo, 32'h0); end
        // Updates requested while reset is held must be ignored.
        drive_cycle(1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'hCAFEF00D);
        vecCount++; if (bus.ReadHi !== 32'h0) begin errCount++; $display("FAIL reset_hold_hi: got %h want %h", bus.ReadHi, 32'h0); end
        vecCount++; if (bus.ReadLo !== 32'h0) begin errCount++; $display("FAIL reset_hold_lo: got %h want %h", bus.ReadLo, 32'h0); end
        #2;
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_madd_accumulate();
        drive_cycle(1'b0, 1'b1, 1'b0, 32'hFF00FF00, 32'h00FF00FF);
        vecCount++; if (bus.ReadHi !== 32'hFF00FF00) begin errCount++; $display("FAIL madd1_hi: got %h want %h", bus.ReadHi, 32'hFF00FF00); end
        vecCount++; if (bus.ReadLo !== 32'h00FF00FF) begin errCount++; $display("FAIL madd1_lo: got %h want %h", bus.ReadLo, 32'h00FF00FF); end
        drive_cycle(1'b0, 1'b1, 1'b0, 32'h00FF00FF, 32'hFF00FF00);
        vecCount++; if (bus.ReadHi !== 32'hFFFFFFFF) begin errCount++; $display("FAIL madd2_hi: got %h want %h", bus.ReadHi, 32'hFFFFFFFF); end
        vecCount++; if (bus.ReadLo !== 32'hFFFFFFFF) begin errCount++; $display("FAIL madd2_lo: got %h want %h", bus.ReadLo, 32'hFFFFFFFF); end
    endtask

    task automatic test_msub_no_borrow();
        drive_cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd32);
        vecCount++; if (bus.ReadHi !== 32'd0)  begin errCount++; $display("FAIL write0_32_hi: got %h want %h", bus.ReadHi, 32'd0); end
        vecCount++; if (bus.ReadLo !== 32'd32) begin errCount++; $display("FAIL write0_32_lo: got %h want %h", bus.ReadLo, 32'd32); end
        drive_cycle(1'b0, 1'b0, 1'b1, 32'd0, 32'd1024);
        vecCount++; if (bus.ReadHi !== 32'h0)        begin errCount++; $display("FAIL msub_borrow_hi: got %h want %h", bus.ReadHi, 32'h0); end
        vecCount++; if (bus.ReadLo !== 32'hFFFFFC20) begin errCount++; $display("FAIL msub_borrow_lo: got %h want %h", bus.ReadLo, 32'hFFFFFC20); end
        // LO underflow 0 - 1 must not touch HI.
        drive_cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        drive_cycle(1'b0, 1'b0, 1'b1, 32'd0, 32'd1);
        vecCount++; if (bus.ReadHi !== 32'h0)        begin errCount++; $display("FAIL msub_wrap_hi: got %h want %h", bus.ReadHi, 32'h0); end
        vecCount++; if (bus.ReadLo !== 32'hFFFFFFFF) begin errCount++; $display("FAIL msub_wrap_lo: got %h want %h", bus.ReadLo, 32'hFFFFFFFF); end
    endtask

    task automatic test_madd_no_carry();
        drive_cycle(1'b1, 1'b0, 1'b0, 32'd31, 32'hFFFFFFE0);
        drive_cycle(1'b0, 1'b1, 1'b0, 32'd0, 32'hFFFFFFE0);
        vecCount++; if (bus.ReadHi !== 32'd31)       begin errCount++; $display("FAIL madd_carry_hi: got %h want %h", bus.ReadHi, 32'd31); end
        vecCount++; if (bus.ReadLo !== 32'hFFFFFFC0) begin errCount++; $display("FAIL madd_carry_lo: got %h want %h", bus.ReadLo, 32'hFFFFFFC0); end
        // LO wrap FFFFFFFF + 1 and HI wrap FFFFFFFF + 1 in separate lanes.
        drive_cycle(1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        drive_cycle(1'b0, 1'b1, 1'b0, 32'd1, 32'd1);
        vecCount++; if (bus.ReadHi !== 32'h0) begin errCount++; $display("FAIL madd_wrap_hi: got %h want %h", bus.ReadHi, 32'h0); end
        vecCount++; if (bus.ReadLo !== 32'h0) begin errCount++; $display("FAIL madd_wrap_lo: got %h want %h", bus.ReadLo, 32'h0); end
    endtask

    task automatic test_msub_negative();
        drive_cycle(1'b1, 1'b0, 1'b0, 32'd32, 32'hFFFFFFFF);
        drive_cycle(1'b0, 1'b0, 1'b1, 32'd0, 32'd1024);
        vecCount++; if (bus.ReadHi !== 32'd32)       begin errCount++; $display("FAIL msub_neg_hi: got %h want %h", bus.ReadHi, 32'd32); end
        vecCount++; if (bus.ReadLo !== 32'hFFFFFBFF) begin errCount++; $display("FAIL msub_neg_lo: got %h want %h", bus.ReadLo, 32'hFFFFFBFF); end
    endtask

    task automatic test_priority();
        drive_cycle(1'b1, 1'b1, 1'b1, 32'd5, 32'd7);
        vecCount++; if (bus.ReadHi !== 32'd5) begin errCount++; $display("FAIL prio_all_hi: got %h want %h", bus.ReadHi, 32'd5); end
        vecCount++; if (bus.ReadLo !== 32'd7) begin errCount++; $display("FAIL prio_all_lo: got %h want %h", bus.ReadLo, 32'd7); end
        drive_cycle(1'b0, 1'b1, 1'b1, 32'd1, 32'd1);
        vecCount++; if (bus.ReadHi !== 32'd6) begin errCount++; $display("FAIL prio_madd_hi: got %h want %h", bus.ReadHi, 32'd6); end
        vecCount++; if (bus.ReadLo !== 32'd8) begin errCount++; $display("FAIL prio_madd_lo: got %h want %h", bus.ReadLo, 32'd8); end
        drive_cycle(1'b1, 1'b0, 1'b1, 32'd40, 32'd50);
        vecCount++; if (bus.ReadHi !== 32'd40) begin errCount++; $display("FAIL prio_we_ms_hi: got %h want %h", bus.ReadHi, 32'd40); end
        vecCount++; if (bus.ReadLo !== 32'd50) begin errCount++; $display("FAIL prio_we_ms_lo: got %h want %h", bus.ReadLo, 32'd50); end
    endtask

    task automatic test_hold();
        logic [WIDTH-1:0] expHi [0:1];
        logic [WIDTH-1:0] expLo [0:1];
        // Starting from 40/50: Madd 1/2 held two edges -> 41/52 then 42/54.
        expHi[0] = 32'd41; expLo[0] = 32'd52;
        expHi[1] = 32'd42; expLo[1] = 32'd54;
        bus.WriteEn = 1'b0; bus.Madd = 1'b1; bus.Msub = 1'b0;
        bus.WriteHiData = 32'd1; bus.WriteLoData = 32'd2;
        for (int i = 0; i < 2; i++) begin
            @(posedge Clk);
            #1;
            vecCount++; if (bus.ReadHi !== expHi[i]) begin errCount++; $display("FAIL madd_held%0d_hi: got %h want %h", i, bus.ReadHi, expHi[i]); end
            vecCount++; if (bus.ReadLo !== expLo[i]) begin errCount++; $display("FAIL madd_held%0d_lo: got %h want %h", i, bus.ReadLo, expLo[i]); end
        end
        // WriteEn held is idempotent.
        bus.Madd = 1'b0; bus.WriteEn = 1'b1;
        bus.WriteHiData = 32'h12345678; bus.WriteLoData = 32'h9ABCDEF0;
        for (int i = 0; i < 2; i++) begin
            @(posedge Clk);
            #1;
            vecCount++; if (bus.ReadHi !== 32'h12345678) begin errCount++; $display("FAIL we_held%0d_hi: got %h want %h", i, bus.ReadHi, 32'h12345678); end
            vecCount++; if (bus.ReadLo !== 32'h9ABCDEF0) begin errCount++; $display("FAIL we_held%0d_lo: got %h want %h", i, bus.ReadLo, 32'h9ABCDEF0); end
        end
        // No control: contents hold even with operands changing.
        bus.WriteEn = 1'b0;
        bus.WriteHiData = 32'hFFFFFFFF; bus.WriteLoData = 32'h11111111;
        repeat (2) @(posedge Clk);
        #1;
        vecCount++; if (bus.ReadHi !== 32'h12345678) begin errCount++; $display("FAIL idle_hi: got %h want %h", bus.ReadHi, 32'h12345678); end
        vecCount++; if (bus.ReadLo !== 32'h9ABCDEF0) begin errCount++; $display("FAIL idle_lo: got %h want %h", bus.ReadLo, 32'h9ABCDEF0); end
    endtask

    task automatic test_async_reset();
        drive_cycle(1'b1, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A);
        #2;
        Reset_n = 1'b0;
        #1;
        vecCount++; if (bus.ReadHi !== 32'h0) begin errCount++; $display("FAIL async_rst_hi: got %h want %h", bus.ReadHi, 32'h0); end
        vecCount++; if (bus.ReadLo !== 32'h0) begin errCount++; $display("FAIL async_rst_lo: got %h want %h", bus.ReadLo, 32'h0); end
        #2;
        Reset_n = 1'b1;
        // First edge after release applies the update normally.
        drive_cycle(1'b0, 1'b1, 1'b0, 32'd3, 32'd4);
        vecCount++; if (bus.ReadHi !== 32'd3) begin errCount++; $display("FAIL post_rst_hi: got %h want %h", bus.ReadHi, 32'd3); end
        vecCount++; if (bus.ReadLo !== 32'd4) begin errCount++; $display("FAIL post_rst_lo: got %h want %h", bus.ReadLo, 32'd4); end
    endtask

    initial begin
        vecCount = 0;
        errCount = 0;
        test_reset();
        test_madd_accumulate();
        test_msub_no_borrow();
        test_madd_no_carry();
        test_msub_negative();
        test_priority();
        test_hold();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
